// File: rtl/rr_pkt_stream_arbiter.sv
// rr_pkt_stream_arbiter
//   Packet-granular round-robin arbiter that shares one AXI4-Stream master
//   between two AXI4-Stream slave requesters. A granted packet is forwarded
//   beat-for-beat up to TLAST without interleaving. There is one idle
//   arbitration cycle before each packet. Per-port completed-packet counters
//   are exported for the register block.
//
// Ports
//   AXI_ACLK, AXI_RESETN          clock, asynchronous active-low reset
//   S0_AXIS_*                     requester 0 stream (TDATA/TSTRB/TUSER/TVALID/TLAST in, TREADY out)
//   S1_AXIS_*                     requester 1 stream
//   M_AXIS_*                      shared datapath stream (TREADY in, the rest out)
//   pkt_count_0, pkt_count_1      packets completed from S0 / S1 (wrap silently)
//   busy                          high while a packet is in flight
module rr_pkt_stream_arbiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32
) (
    input  logic                              AXI_ACLK,
    input  logic                              AXI_RESETN,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S0_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S0_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S0_AXIS_TUSER,
    input  logic                              S0_AXIS_TVALID,
    input  logic                              S0_AXIS_TLAST,
    output logic                              S0_AXIS_TREADY,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S1_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S1_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S1_AXIS_TUSER,
    input  logic                              S1_AXIS_TVALID,
    input  logic                              S1_AXIS_TLAST,
    output logic                              S1_AXIS_TREADY,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic                              M_AXIS_TVALID,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY,

    output logic [C_S_AXI_DATA_WIDTH-1:0]     pkt_count_0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     pkt_count_1,
    output logic                              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state, state_next;
    logic   grant, grant_next;
    logic   last_grant, last_grant_next;

    logic [C_S_AXIS_DATA_WIDTH-1:0]   sel_data;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0] sel_strb;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  sel_user;
    logic                             sel_valid;
    logic                             sel_last;
    logic                             active;
    logic                             pkt_done;

    // Source selected by the current grant; only meaningful in SEND.
    assign sel_data  = grant ? S1_AXIS_TDATA  : S0_AXIS_TDATA;
    assign sel_strb  = grant ? S1_AXIS_TSTRB  : S0_AXIS_TSTRB;
    assign sel_user  = grant ? S1_AXIS_TUSER  : S0_AXIS_TUSER;
    assign sel_valid = grant ? S1_AXIS_TVALID : S0_AXIS_TVALID;
    assign sel_last  = grant ? S1_AXIS_TLAST  : S0_AXIS_TLAST;

    // Gating with the reset keeps every handshake output low while reset is held.
    assign active   = (state == SEND) && AXI_RESETN;
    assign pkt_done = active && sel_valid && M_AXIS_TREADY && sel_last;

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            pkt_count_0 <= '0;
            pkt_count_1 <= '0;
        end else if (pkt_done) begin
            if (grant) begin
                pkt_count_1 <= pkt_count_1 + 1'b1;
            end else begin
                pkt_count_0 <= pkt_count_0 + 1'b1;
            end
        end
    end

    // A tie goes to the port that did not finish the previous packet.
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        case (state)
            IDLE: begin
                if (S0_AXIS_TVALID && S1_AXIS_TVALID) begin
                    grant_next = ~last_grant;
                    state_next = SEND;
                end else if (S0_AXIS_TVALID) begin
                    grant_next = 1'b0;
                    state_next = SEND;
                end else if (S1_AXIS_TVALID) begin
                    grant_next = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (pkt_done) begin
                    last_grant_next = grant;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Master side is a pure combinational pass-through of the granted port.
    always_comb begin
        M_AXIS_TDATA   = '0;
        M_AXIS_TSTRB   = '0;
        M_AXIS_TUSER   = '0;
        M_AXIS_TLAST   = 1'b0;
        M_AXIS_TVALID  = 1'b0;
        S0_AXIS_TREADY = 1'b0;
        S1_AXIS_TREADY = 1'b0;
        busy           = 1'b0;
        if (active) begin
            M_AXIS_TDATA  = sel_data;
            M_AXIS_TSTRB  = sel_strb;
            M_AXIS_TUSER  = sel_user;
            M_AXIS_TLAST  = sel_last;
            M_AXIS_TVALID = sel_valid;
            busy          = 1'b1;
            if (grant) begin
                S1_AXIS_TREADY = M_AXIS_TREADY;
            end else begin
                S0_AXIS_TREADY = M_AXIS_TREADY;
            end
        end
    end

endmodule

// File: tb/tb_rr_pkt_stream_arbiter.sv
// tb_rr_pkt_stream_arbiter
//   Bench for rr_pkt_stream_arbiter. A behavioural model (packet owner,
//   previous winner, per-port packet totals) predicts every output each
//   cycle; directed scenarios plus a randomized phase drive the two slave
//   ports and the master ready.
module tb_rr_pkt_stream_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] s0_data = '0, s1_data = '0;
    logic [31:0]  s0_strb = '0, s1_strb = '0;
    logic [127:0] s0_user = '0, s1_user = '0;
    logic         s0_valid = 1'b0, s1_valid = 1'b0;
    logic         s0_last = 1'b0, s1_last = 1'b0;
    logic         s0_ready, s1_ready;
    logic [255:0] m_data;
    logic [31:0]  m_strb;
    logic [127:0] m_user;
    logic         m_valid, m_last;
    logic         m_ready = 1'b1;
    logic [31:0]  cnt0, cnt1;
    logic         busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ser[2];

    // Behavioural model state: who owns the master (-1 = nobody), who won last.
    int          mdl_owner = -1;
    int          mdl_prev = 1;
    logic [31:0] mdl_cnt[2];

    // Observation logs used by the literal checks.
    int order_q[$];
    int xfer_cyc_q[$];

    rr_pkt_stream_arbiter dut (
        .AXI_ACLK       (clk),
        .AXI_RESETN     (rst_n),
        .S0_AXIS_TDATA  (s0_data),
        .S0_AXIS_TSTRB  (s0_strb),
        .S0_AXIS_TUSER  (s0_user),
        .S0_AXIS_TVALID (s0_valid),
        .S0_AXIS_TLAST  (s0_last),
        .S0_AXIS_TREADY (s0_ready),
        .S1_AXIS_TDATA  (s1_data),
        .S1_AXIS_TSTRB  (s1_strb),
        .S1_AXIS_TUSER  (s1_user),
        .S1_AXIS_TVALID (s1_valid),
        .S1_AXIS_TLAST  (s1_last),
        .S1_AXIS_TREADY (s1_ready),
        .M_AXIS_TDATA   (m_data),
        .M_AXIS_TSTRB   (m_strb),
        .M_AXIS_TUSER   (m_user),
        .M_AXIS_TVALID  (m_valid),
        .M_AXIS_TLAST   (m_last),
        .M_AXIS_TREADY  (m_ready),
        .pkt_count_0    (cnt0),
        .pkt_count_1    (cnt1),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model check and advance, once per cycle while inputs are stable.
    always @(negedge clk) begin
        logic         iv[2];
        logic         il[2];
        logic [255:0] id[2];
        logic [31:0]  is[2];
        logic [127:0] iu[2];
        logic         e_valid, e_last, e_busy;
        logic         e_rdy[2];
        logic [255:0] e_data;
        logic [31:0]  e_strb;
        logic [127:0] e_user;
        iv[0] = s0_valid; iv[1] = s1_valid;
        il[0] = s0_last;  il[1] = s1_last;
        id[0] = s0_data;  id[1] = s1_data;
        is[0] = s0_strb;  is[1] = s1_strb;
        iu[0] = s0_user;  iu[1] = s1_user;
        if (!rst_n) begin
            mdl_owner  = -1;
            mdl_prev   = 1;
            mdl_cnt[0] = '0;
            mdl_cnt[1] = '0;
        end
        e_valid = 1'b0; e_last = 1'b0; e_busy = 1'b0;
        e_data = '0; e_strb = '0; e_user = '0;
        e_rdy[0] = 1'b0; e_rdy[1] = 1'b0;
        if (rst_n && mdl_owner >= 0) begin
            e_valid = iv[mdl_owner];
            e_last  = il[mdl_owner];
            e_data  = id[mdl_owner];
            e_strb  = is[mdl_owner];
            e_user  = iu[mdl_owner];
            e_rdy[mdl_owner] = m_ready;
            e_busy  = 1'b1;
        end
        checkOutput("m_valid", m_valid, e_valid);
        checkOutput("m_last", m_last, e_last);
        checkOutput("m_data", m_data, e_data);
        checkOutput("m_strb", m_strb, e_strb);
        checkOutput("m_user", m_user, e_user);
        checkOutput("s0_ready", s0_ready, e_rdy[0]);
        checkOutput("s1_ready", s1_ready, e_rdy[1]);
        checkOutput("busy", busy, e_busy);
        checkOutput("pkt_count_0", cnt0, mdl_cnt[0]);
        checkOutput("pkt_count_1", cnt1, mdl_cnt[1]);
        if (m_valid && m_ready) begin
            xfer_cyc_q.push_back(cyc);
            if (m_last) order_q.push_back(int'(m_data[255:248]));
        end
        if (rst_n) begin
            if (mdl_owner < 0) begin
                if (iv[0] && iv[1]) mdl_owner = 1 - mdl_prev;
                else if (iv[0])     mdl_owner = 0;
                else if (iv[1])     mdl_owner = 1;
            end else if (iv[mdl_owner] && m_ready && il[mdl_owner]) begin
                mdl_cnt[mdl_owner] = mdl_cnt[mdl_owner] + 1;
                mdl_prev  = mdl_owner;
                mdl_owner = -1;
            end
        end
    end

    task automatic setPort(input int p, input logic v, input logic [255:0] d, input logic [31:0] s,
                           input logic [127:0] u, input logic l);
        if (p == 0) begin
            s0_valid = v; s0_data = d; s0_strb = s; s0_user = u; s0_last = l;
        end else begin
            s1_valid = v; s1_data = d; s1_strb = s; s1_user = u; s1_last = l;
        end
    endtask

    function automatic logic [255:0] mkData(input int p, input int b);
        return {8'(p), 16'(ser[p]), 192'(0), 8'(b), 32'($urandom)};
    endfunction

    // Sends one packet on port p; called and returning at posedge+1.
    // 'gap' idle cycles are inserted after every non-final beat.
    task automatic applyStimulus(input int p, input int len, input int gap);
        int waited;
        logic rdy;
        for (int b = 0; b < len; b++) begin
            setPort(p, 1'b1, mkData(p, b), $urandom, {$urandom, $urandom, $urandom, $urandom}, b == len - 1);
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
                rdy = (p == 0) ? s0_ready : s1_ready;
            end while (!rdy && waited < 300);
            if (!rdy) begin
                total = total + 1;
                bad = bad + 1;
                $display("[TB] FAIL accept_timeout: port %0d beat %0d got no ready, required ready within 300 cycles", p, b);
            end
            @(posedge clk); #1;
            if (gap > 0 && b < len - 1) begin
                setPort(p, 1'b0, '0, '0, '0, 1'b0);
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
        setPort(p, 1'b0, '0, '0, '0, 1'b0);
        ser[p] = ser[p] + 1;
    endtask

    task automatic sendRandom(input int p, input int npkts);
        for (int k = 0; k < npkts; k++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            applyStimulus(p, $urandom_range(1, 4), $urandom_range(0, 1));
        end
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic clearLogs();
        order_q.delete();
        xfer_cyc_q.delete();
    endtask

    initial begin
        int start_cyc;
        logic toggle_stop;
        logic rnd_done;
        ser[0] = 0; ser[1] = 0;
        mdl_cnt[0] = '0; mdl_cnt[1] = '0;
        @(posedge clk); #1;
        pulseReset();

        // Reset values
        checkOutput("reset_cnt0", cnt0, 32'd0);
        checkOutput("reset_busy", busy, 1'b0);

        // 3-beat S0 packet, first beat one cycle after TVALID rises
        clearLogs();
        start_cyc = cyc;
        applyStimulus(0, 3, 0);
        @(posedge clk); #1;
        checkOutput("t1_first_beat_cycle", 256'(xfer_cyc_q[0] - start_cyc), 256'd1);
        checkOutput("t1_beats", 256'(xfer_cyc_q.size()), 256'd3);
        checkOutput("t1_count0", cnt0, 32'd1);

        // Both valid from reset, two single-beat packets each
        pulseReset();
        clearLogs();
        fork
            begin applyStimulus(0, 1, 0); applyStimulus(0, 1, 0); end
            begin applyStimulus(1, 1, 0); applyStimulus(1, 1, 0); end
        join
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("t2_npkts", 256'(order_q.size()), 256'd4);
        if (order_q.size() == 4) begin
            checkOutput("t2_order0", 256'(order_q[0]), 256'd0);
            checkOutput("t2_order1", 256'(order_q[1]), 256'd1);
            checkOutput("t2_order2", 256'(order_q[2]), 256'd0);
            checkOutput("t2_order3", 256'(order_q[3]), 256'd1);
            checkOutput("t2_bubble", 256'(xfer_cyc_q[1] - xfer_cyc_q[0]), 256'd2);
        end
        checkOutput("t2_count0", cnt0, 32'd2);
        checkOutput("t2_count1", cnt1, 32'd2);

        // S1 packet with M ready toggling every cycle
        clearLogs();
        toggle_stop = 1'b0;
        fork
            begin applyStimulus(1, 3, 0); toggle_stop = 1'b1; end
            begin
                while (!toggle_stop) begin
                    @(posedge clk); #1;
                    if (!toggle_stop) m_ready = ~m_ready;
                end
            end
        join
        m_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("t3_beats", 256'(xfer_cyc_q.size()), 256'd3);
        checkOutput("t3_count1", cnt1, 32'd3);

        // S0 stalls mid-packet while S1 waits
        clearLogs();
        fork
            applyStimulus(0, 3, 2);
            applyStimulus(1, 1, 0);
        join
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("t4_npkts", 256'(order_q.size()), 256'd2);
        if (order_q.size() == 2) begin
            checkOutput("t4_first", 256'(order_q[0]), 256'd0);
            checkOutput("t4_second", 256'(order_q[1]), 256'd1);
        end

        // Counter wrap
        force dut.pkt_count_0 = 32'hFFFF_FFFF;
        mdl_cnt[0] = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.pkt_count_0;
        applyStimulus(0, 2, 0);
        @(posedge clk); #1;
        checkOutput("t5_wrap", cnt0, 32'd0);

        // Randomized traffic with random master backpressure
        rnd_done = 1'b0;
        fork
            begin
                fork
                    sendRandom(0, 25);
                    sendRandom(1, 25);
                join
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    m_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end

        // Asynchronous reset on beat 2 of a 4-beat S1 packet
        setPort(1, 1'b1, mkData(1, 0), '0, '0, 1'b0);
        begin
            int accepted = 0;
            int waited = 0;
            while (accepted < 2 && waited < 50) begin
                @(negedge clk);
                waited++;
                if (s1_ready) accepted++;
                @(posedge clk); #1;
                if (s1_ready === 1'bx) accepted = 0;
                setPort(1, 1'b1, mkData(1, accepted), '0, '0, 1'b0);
            end
            checkOutput("t6_beats_before_reset", 256'(accepted), 256'd2);
        end
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t6_s0_ready", s0_ready, 1'b0);
        checkOutput("t6_s1_ready", s1_ready, 1'b0);
        checkOutput("t6_m_valid", m_valid, 1'b0);
        checkOutput("t6_busy", busy, 1'b0);
        checkOutput("t6_cnt0", cnt0, 32'd0);
        checkOutput("t6_cnt1", cnt1, 32'd0);
        setPort(1, 1'b0, '0, '0, '0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clearLogs();
        fork
            applyStimulus(0, 1, 0);
            applyStimulus(1, 1, 0);
        join
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("t6_npkts", 256'(order_q.size()), 256'd2);
        if (order_q.size() == 2) begin
            checkOutput("t6_tie_winner", 256'(order_q[0]), 256'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
